// File: rtl/icache_fetch_initiator_pkg.sv
// Shared types for the instruction-fetch initiator: widths, reset PC, FSM encoding
// and the {pc, inst} fetch-queue entry.
package icache_fetch_initiator_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_START = 32'h0000_0200;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with push/pop/flush; head is read from registered
// storage and forced to zero while the queue is empty.
module fetch_queue
  import icache_fetch_initiator_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  output fetch_entry_t                 head_entry,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign do_pop     = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push    = push && (!full || do_pop);
  assign head_entry = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/icache_fetch_initiator.sv
// Core-side icache fetch initiator: sequential word fetches, redirect/kill handling and
// a small decode queue. ICACHE_FETCH_FORMAL_EN compiles in FORMAL-guarded assertions.
module icache_fetch_initiator #(
  parameter int                                  XLEN     = icache_fetch_initiator_pkg::XLEN,
  parameter int                                  FQ_DEPTH = 4,
  parameter logic [XLEN-1:0]                     RESET_PC = icache_fetch_initiator_pkg::PC_START
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   redirect_valid,
  input  logic [XLEN-1:0]                        redirect_pc,
  output logic                                   io_icache_req_valid,
  output logic [XLEN-1:0]                        io_icache_req_bits_addr,
  output logic [XLEN-1:0]                        io_icache_req_bits_data,
  output logic [3:0]                             io_icache_req_bits_mask,
  input  logic                                   io_icache_resp_valid,
  input  logic [XLEN-1:0]                        io_icache_resp_bits_data,
  output logic                                   inst_valid,
  output logic [XLEN-1:0]                        inst_bits,
  output logic [XLEN-1:0]                        inst_pc,
  input  logic                                   inst_ready,
  output icache_fetch_initiator_pkg::fetch_state_e debug_state
);

  import icache_fetch_initiator_pkg::*;

  // Handshake: a request stays valid with a stable address until io_icache_resp_valid
  // is seen at a rising edge; a queue entry leaves when inst_valid && inst_ready.
  localparam int CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_next;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] redirect_target;
  logic            req_valid_q;
  logic            resp_accept;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_after;
  logic            has_room;
  logic            q_full;
  logic            q_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  assign redirect_target = word_align(redirect_pc);
  assign fetch_pc_next   = fetch_pc + XLEN'(4);

  // Responses only enqueue from WAIT; a same-cycle redirect drops them.
  assign resp_accept = (state == WAIT) && io_icache_resp_valid && !redirect_valid;
  assign pop         = inst_valid && inst_ready && !redirect_valid;
  assign push        = resp_accept && (!q_full || pop);
  assign push_entry  = '{pc: fetch_pc, inst: io_icache_resp_bits_data};

  // Issue only when the response of the next request is guaranteed a slot.
  assign count_after = count + CW'(push) - CW'(pop);
  assign has_room    = count_after < CW'(FQ_DEPTH);

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .full       (q_full),
    .empty      (q_empty),
    .count      (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      req_addr    <= RESET_PC;
      req_valid_q <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_target;
      req_valid_q <= 1'b1;
      if (state == IDLE || io_icache_resp_valid) begin
        state    <= WAIT;
        req_addr <= redirect_target;
      end else begin
        // The outstanding request keeps its old address until its response drains.
        state <= KILL;
      end
    end else begin
      case (state)
        IDLE: begin
          if (has_room) begin
            state       <= WAIT;
            req_valid_q <= 1'b1;
            req_addr    <= fetch_pc;
          end
        end
        WAIT: begin
          if (io_icache_resp_valid) begin
            fetch_pc <= fetch_pc_next;
            req_addr <= fetch_pc_next;
            if (!has_room) begin
              state       <= IDLE;
              req_valid_q <= 1'b0;
            end
          end
        end
        KILL: begin
          if (io_icache_resp_valid) begin
            state    <= WAIT;
            req_addr <= fetch_pc;
          end
        end
        default: begin
          state       <= IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign io_icache_req_valid     = req_valid_q;
  assign io_icache_req_bits_addr = req_addr;
  assign io_icache_req_bits_data = '0;
  assign io_icache_req_bits_mask = '0;
  assign inst_valid              = !q_empty;
  assign inst_bits               = head_entry.inst;
  assign inst_pc                 = head_entry.pc;
  assign debug_state             = state;

`ifdef ICACHE_FETCH_FORMAL_EN
`ifdef FORMAL
  logic            f_past_valid;
  logic            f_hold;
  logic [XLEN-1:0] f_addr;

  always_ff @(posedge clock) begin
    f_past_valid <= !reset;
    f_hold       <= (state != IDLE) && !io_icache_resp_valid && !reset;
    f_addr       <= req_addr;
  end

  always @(posedge clock) begin
    if (!reset) begin
      if (f_past_valid && f_hold) assert (req_addr == f_addr);
      assert (count <= CW'(FQ_DEPTH));
      assert (!(resp_accept && q_full && !pop));
      assert (!(state == KILL && push));
      assert (req_addr[1:0] == 2'b00);
    end
  end
`endif
`endif

endmodule
